mouse_key_decoder: RTL and testbench
====================================

MOUSE_KEY_DECODER -- requirements
Module: mouse_key_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive samples needed to accept a press or release (legal 2..255).
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port mousex, input, 10: cursor X in screen pixels.
REQ-005 SHALL have port mousey, input, 10: cursor Y in screen pixels.
REQ-006 SHALL have port btn_left, input, 1: left mouse button level, 1 = pressed, already synchronous to clk.
REQ-007 SHALL have port key_code, output, 7: code of the decoded key.
REQ-008 SHALL have port key_valid, output, 1: key_code holds a decoded key.
REQ-009 SHALL have port key_ready, input, 1: consumer accepts key_code when key_valid=1 and key_ready=1.
REQ-010 SHALL have port miss, output, 1: one-cycle pulse when an accepted press falls outside every key.

Function
REQ-011 SHALL hit-test the latched coordinates against inclusive boxes using 10-bit unsigned compares.
- Column X ranges: [90,154], [218,282], [346,410], [474,538].
- Row Y ranges: [150,214], [239,303], [328,392], [417,481].
- Clear key box: X [560,624], Y [150,214].
REQ-012 SHALL assign key codes by row (columns 0..3 left to right); the clear key SHALL return 67 ("C").
- Row 0: 1, 2, 3, 96.
- Row 1: 4, 5, 6, 97.
- Row 2: 7, 8, 9, 98.
- Row 3: 0, 99, 100, 101.
REQ-013 SHALL implement the FSM states IDLE, ARMING, DECODE, PRESENT and WAIT_RELEASE.
REQ-014 In IDLE, SHALL on btn_left=1 enter ARMING with the debounce count set to 1; otherwise it SHALL stay in IDLE.
REQ-015 In ARMING with btn_left=1:
- if count == DEBOUNCE_CYCLES-1, SHALL latch mousex and mousey and enter DECODE;
- otherwise SHALL increment count.
REQ-016 In ARMING with btn_left=0, SHALL clear the count and return to IDLE; a glitch shorter than DEBOUNCE_CYCLES samples produces no output.
REQ-017 DECODE SHALL last exactly one cycle.
- On a hit: SHALL register key_code and enter PRESENT.
- On a miss: SHALL assert miss for exactly the next cycle and enter WAIT_RELEASE.
REQ-018 In PRESENT, key_valid SHALL be 1 and key_code SHALL be stable until the handshake; btn_left and mouse motion SHALL NOT affect either.
REQ-019 On the handshake (PRESENT, key_ready=1), SHALL enter WAIT_RELEASE; key_valid SHALL be 0 from the following cycle.
REQ-020 WAIT_RELEASE SHALL count consecutive btn_left=0 samples.
- Any sample with btn_left=1 SHALL clear the count.
- After DEBOUNCE_CYCLES consecutive low samples, SHALL enter IDLE.
- A held button SHALL therefore never produce a second key.
REQ-021 Latency: with edge 0 as the first edge sampling btn_left=1 and the button held, key_valid (or miss) SHALL be high in the cycle after edge DEBOUNCE_CYCLES.
REQ-022 key_ready while key_valid=0 SHALL be ignored.
REQ-023 key_code SHALL keep its last value after the handshake until the next hit.
REQ-024 At most one key SHALL be outstanding; there is no queue, and presses are only sampled in IDLE/ARMING.
REQ-025 Coordinates exactly on a box edge SHALL count as a hit; one pixel outside SHALL count as a miss.

Reset
REQ-026 On reset=1 at a clock edge, the block SHALL enter IDLE and clear key_valid, miss, key_code (to 0), the debounce count and the latched coordinates, from any state including PRESENT.
REQ-027 After reset deasserts, a button already held SHALL be treated as a new press through ARMING.

Verification
REQ-028 Press at (100,160), held 12 cycles, key_ready=1 -> key_valid high one cycle after edge 4, key_code=1, exactly one handshake, no miss.
REQ-029 Press at (500,450) -> key_code=101; press at (624,214) -> key_code=67; press at (155,214) -> miss pulse for 1 cycle, key_valid stays 0.
REQ-030 btn_left high for 3 cycles with DEBOUNCE_CYCLES=4 -> no key_valid and no miss; FSM back in IDLE.
REQ-031 Press at (350,330), key_ready=0 for 20 cycles while the mouse moves and is released -> key_valid=1, key_code=9 constant; handshake on ready=1; valid drops next cycle.
REQ-032 Hold the button for 50 cycles after the handshake -> no second key; release for 4 cycles then press (230,250) -> key_code=5.
REQ-033 reset=1 during PRESENT -> key_valid=0 and key_code=0 the next cycle; button still held -> new key after re-arming.

Source files
------------

// File: rtl/mouse_key_decoder.sv
// On-screen keypad decoder: debounces the left mouse button, hit-tests the
// latched cursor position against the key boxes and presents one key per press.
//
// state           | meaning
// ----------------+--------------------------------------------------------
// ST_IDLE         | waiting for the first high sample of btn_left
// ST_ARMING       | counting consecutive high samples toward acceptance
// ST_DECODE       | one cycle: hit-test latched coordinates
// ST_PRESENT      | key_valid high, holding key_code until the handshake
// ST_WAIT_RELEASE | counting consecutive low samples before re-arming
module mouse_key_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] mousex,
    input  logic [9:0] mousey,
    input  logic       btn_left,
    output logic [6:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       miss
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMING,
        ST_DECODE,
        ST_PRESENT,
        ST_WAIT_RELEASE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0] CODE_CLEAR = 7'd67;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [6:0] key_code_q, key_code_d;
    logic       miss_q, miss_d;

    logic       col_hit, row_hit, clear_hit, hit;
    logic [1:0] col_idx, row_idx;
    logic [6:0] hit_code;

    function automatic logic in_range(input logic [9:0] v,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [6:0] key_lookup(input logic [1:0] row,
                                              input logic [1:0] col);
        logic [6:0] code;
        case ({row, col})
            4'h0:    code = 7'd1;
            4'h1:    code = 7'd2;
            4'h2:    code = 7'd3;
            4'h3:    code = 7'd96;
            4'h4:    code = 7'd4;
            4'h5:    code = 7'd5;
            4'h6:    code = 7'd6;
            4'h7:    code = 7'd97;
            4'h8:    code = 7'd7;
            4'h9:    code = 7'd8;
            4'hA:    code = 7'd9;
            4'hB:    code = 7'd98;
            4'hC:    code = 7'd0;
            4'hD:    code = 7'd99;
            4'hE:    code = 7'd100;
            default: code = 7'd101;
        endcase
        return code;
    endfunction

    // Boxes are disjoint, so at most one column and one row can match.
    always_comb begin
        col_hit = 1'b1;
        col_idx = 2'd0;
        if (in_range(x_q, 10'd90, 10'd154)) begin
            col_idx = 2'd0;
        end else if (in_range(x_q, 10'd218, 10'd282)) begin
            col_idx = 2'd1;
        end else if (in_range(x_q, 10'd346, 10'd410)) begin
            col_idx = 2'd2;
        end else if (in_range(x_q, 10'd474, 10'd538)) begin
            col_idx = 2'd3;
        end else begin
            col_hit = 1'b0;
        end

        row_hit = 1'b1;
        row_idx = 2'd0;
        if (in_range(y_q, 10'd150, 10'd214)) begin
            row_idx = 2'd0;
        end else if (in_range(y_q, 10'd239, 10'd303)) begin
            row_idx = 2'd1;
        end else if (in_range(y_q, 10'd328, 10'd392)) begin
            row_idx = 2'd2;
        end else if (in_range(y_q, 10'd417, 10'd481)) begin
            row_idx = 2'd3;
        end else begin
            row_hit = 1'b0;
        end

        clear_hit = in_range(x_q, 10'd560, 10'd624) && in_range(y_q, 10'd150, 10'd214);
        hit       = clear_hit || (col_hit && row_hit);
        hit_code  = clear_hit ? CODE_CLEAR : key_lookup(row_idx, col_idx);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        key_code_d = key_code_q;
        miss_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (btn_left) begin
                    cnt_d   = 8'd1;
                    state_d = ST_ARMING;
                end
            end
            ST_ARMING: begin
                if (!btn_left) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    x_d     = mousex;
                    y_d     = mousey;
                    state_d = ST_DECODE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DECODE: begin
                cnt_d = 8'd0;
                if (hit) begin
                    key_code_d = hit_code;
                    state_d    = ST_PRESENT;
                end else begin
                    miss_d  = 1'b1;
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_PRESENT: begin
                // Button and cursor are deliberately ignored until the consumer takes the key.
                if (key_ready) begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (btn_left) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            key_code_q <= 7'd0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            key_code_q <= key_code_d;
            miss_q     <= miss_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = (state_q == ST_PRESENT);
    assign miss      = miss_q;

endmodule

// File: tb/tb_mouse_key_decoder.sv
// Directed bench for mouse_key_decoder: latency, key map edges, debounce,
// backpressure, held-button suppression and reset during PRESENT.
module tb_mouse_key_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] mousex, mousey;
    logic       btn_left;
    logic [6:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       miss;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int miss_cnt = 0;
    int valid_cnt = 0;
    int last_code = 0;

    mouse_key_decoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mousex    (mousex),
        .mousey    (mousey),
        .btn_left  (btn_left),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .miss      (miss)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid && key_ready) hs_cnt++;
        if (miss) miss_cnt++;
        if (key_valid) valid_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        hs_cnt    = 0;
        miss_cnt  = 0;
        valid_cnt = 0;
    endtask

    // Starts in IDLE with btn_left low; presses with key_ready=1 and checks latency.
    task automatic press_and_check(input string tag, input int x, input int y,
                                   input int exp_code, input bit exp_hit);
        clear_counts();
        mousex    = 10'(x);
        mousey    = 10'(y);
        key_ready = 1'b1;
        btn_left  = 1'b1;
        repeat (4) tick();
        chk({tag, ".early"}, int'(key_valid | miss), 0);
        tick();
        chk({tag, ".valid"}, int'(key_valid), int'(exp_hit));
        chk({tag, ".miss"}, int'(miss), int'(!exp_hit));
        if (exp_hit) last_code = exp_code;
        chk({tag, ".code"}, int'(key_code), last_code);
        tick();
        chk({tag, ".after"}, int'(key_valid | miss), 0);
        repeat (3) tick();
        btn_left = 1'b0;
        repeat (6) tick();
        chk({tag, ".hs_cnt"}, hs_cnt, int'(exp_hit));
        chk({tag, ".miss_cnt"}, miss_cnt, int'(!exp_hit));
        key_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        mousex    = 10'd0;
        mousey    = 10'd0;
        btn_left  = 1'b0;
        key_ready = 1'b0;
        repeat (3) tick();
        chk("rst.valid", int'(key_valid), 0);
        chk("rst.miss", int'(miss), 0);
        chk("rst.code", int'(key_code), 0);
        reset = 1'b0;
        tick();

        // Basic press, held 12 cycles, one handshake
        clear_counts();
        mousex = 10'd100; mousey = 10'd160; key_ready = 1'b1; btn_left = 1'b1;
        repeat (4) tick();
        chk("basic.early", int'(key_valid), 0);
        tick();
        chk("basic.valid", int'(key_valid), 1);
        chk("basic.code", int'(key_code), 1);
        tick();
        chk("basic.drop", int'(key_valid), 0);
        repeat (6) tick();
        btn_left = 1'b0;
        repeat (6) tick();
        chk("basic.hs_cnt", hs_cnt, 1);
        chk("basic.miss_cnt", miss_cnt, 0);
        last_code = 1;
        key_ready = 1'b0;

        press_and_check("k101", 500, 450, 101, 1'b1);
        press_and_check("clr_corner", 624, 214, 67, 1'b1);
        press_and_check("miss_155", 155, 214, 0, 1'b0);
        press_and_check("k1_corner", 90, 150, 1, 1'b1);
        press_and_check("miss_89", 89, 150, 0, 1'b0);
        press_and_check("k101_corner", 538, 481, 101, 1'b1);
        press_and_check("k96", 474, 150, 96, 1'b1);
        press_and_check("k9_edge", 410, 392, 9, 1'b1);
        press_and_check("k5_edge", 282, 303, 5, 1'b1);
        press_and_check("k0", 154, 481, 0, 1'b1);
        press_and_check("clr_lo", 560, 150, 67, 1'b1);
        press_and_check("miss_625", 625, 214, 0, 1'b0);
        press_and_check("miss_215", 624, 215, 0, 1'b0);
        press_and_check("miss_482", 346, 482, 0, 1'b0);
        press_and_check("miss_gap", 200, 230, 0, 1'b0);

        // Glitch shorter than the debounce window
        clear_counts();
        mousex = 10'd100; mousey = 10'd160; key_ready = 1'b1; btn_left = 1'b1;
        repeat (3) tick();
        btn_left = 1'b0;
        repeat (8) tick();
        chk("glitch.valid_cnt", valid_cnt, 0);
        chk("glitch.miss_cnt", miss_cnt, 0);
        key_ready = 1'b0;
        press_and_check("glitch.idle", 230, 250, 5, 1'b1);

        // Backpressure while mouse moves and button releases
        clear_counts();
        mousex = 10'd350; mousey = 10'd330; key_ready = 1'b0; btn_left = 1'b1;
        repeat (5) tick();
        for (int i = 0; i < 20; i++) begin
            chk("bp.valid", int'(key_valid), 1);
            chk("bp.code", int'(key_code), 9);
            mousex   = 10'($urandom_range(0, 1023));
            mousey   = 10'($urandom_range(0, 1023));
            btn_left = (i < 8) ? 1'b1 : ((i % 3) == 0);
            tick();
        end
        btn_left  = 1'b0;
        chk("bp.hs_before", hs_cnt, 0);
        key_ready = 1'b1;
        tick();
        chk("bp.drop", int'(key_valid), 0);
        chk("bp.hs_cnt", hs_cnt, 1);
        chk("bp.code_kept", int'(key_code), 9);
        key_ready = 1'b0;
        repeat (6) tick();
        last_code = 9;

        // Held button after handshake yields no second key
        clear_counts();
        mousex = 10'd100; mousey = 10'd160; key_ready = 1'b1; btn_left = 1'b1;
        repeat (6) tick();
        chk("hold.hs_cnt", hs_cnt, 1);
        clear_counts();
        repeat (50) tick();
        chk("hold.valid_cnt", valid_cnt, 0);
        chk("hold.miss_cnt", miss_cnt, 0);
        btn_left = 1'b0;
        repeat (4) tick();
        last_code = 1;
        press_and_check("hold.next", 230, 250, 5, 1'b1);

        // Reset while PRESENT with the button still held
        mousex = 10'd100; mousey = 10'd160; key_ready = 1'b0; btn_left = 1'b1;
        repeat (5) tick();
        chk("rp.valid", int'(key_valid), 1);
        chk("rp.code", int'(key_code), 1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("rp.rst_valid", int'(key_valid), 0);
        chk("rp.rst_code", int'(key_code), 0);
        reset = 1'b0;
        repeat (4) tick();
        chk("rp.rearm_early", int'(key_valid), 0);
        tick();
        chk("rp.rearm_valid", int'(key_valid), 1);
        chk("rp.rearm_code", int'(key_code), 1);
        key_ready = 1'b1;
        tick();
        chk("rp.drop", int'(key_valid), 0);
        key_ready = 1'b0;
        btn_left  = 1'b0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
